// File: rtl/holy_core_pkg.sv
// Shared core definitions: funct3 encodings, LSU state encoding and defaults.
package holy_core_pkg;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/load_data_extender.sv
// Aligns a returned memory word to the access offset and sign/zero-extends it.
module load_data_extender
    import holy_core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = '0;
        case (f3)
            F3_BYTE:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BYTE_U: data = {24'b0, shifted[7:0]};
            F3_HALF:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HALF_U: data = {16'b0, shifted[15:0]};
            F3_WORD:   data = shifted;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/response transaction per access, stalls meanwhile.
// Optional watchdog with bus_error output enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import holy_core_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_f3,
    input  logic [3:0]        req_byte_enable,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              misaligned,
`ifdef LSU_TIMEOUT_EN
    output logic              bus_error,
`endif
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("load_store_unit supports DATA_W == 32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("load_store_unit needs TIMEOUT_CYCLES >= 1");
    end

    lsu_state_t        state;
    lsu_state_t        state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic              write_q;
    logic [3:0]        strb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mis_q;
    logic [DATA_W-1:0] ext_data;
    logic              accept;
    logic              kill_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             berr_q;
    logic             expire;
    logic             timeout_hit;

    // A completing handshake in the expiry cycle takes priority over the error
    assign expire    = (cnt_q >= CNT_LAST);
    assign kill_data = write_q | mis_q | berr_q;
`else
    assign kill_data = write_q | mis_q;
`endif

    assign accept    = (state == IDLE) && req_valid;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wstrb = strb_q;
    assign mem_wdata = wdata_q;

    load_data_extender u_ext (
        .rdata  (rdata_q),
        .offset (addr_q[1:0]),
        .f3     (f3_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            berr_q  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= req_addr;
                f3_q    <= req_f3;
                write_q <= req_write;
                strb_q  <= req_write ? req_byte_enable : 4'b0000;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                mis_q   <= (req_byte_enable == 4'b0000);
`ifdef LSU_TIMEOUT_EN
                cnt_q   <= '0;
                berr_q  <= 1'b0;
`endif
            end
            if ((state == RESP) && mem_resp_valid) begin
                rdata_q <= mem_rdata;
            end
`ifdef LSU_TIMEOUT_EN
            if ((state == REQ) || (state == RESP)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                berr_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_n        = state;
        stall          = 1'b0;
        done           = 1'b0;
        misaligned     = 1'b0;
        load_data      = '0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
`ifdef LSU_TIMEOUT_EN
        bus_error      = 1'b0;
        timeout_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_n = (req_byte_enable == 4'b0000) ? DONE : REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_n = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (expire) begin
                    state_n     = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            RESP: begin
                stall          = 1'b1;
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) begin
                    state_n = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (expire) begin
                    state_n     = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE: begin
                done       = 1'b1;
                misaligned = mis_q;
                load_data  = kill_data ? '0 : ext_data;
`ifdef LSU_TIMEOUT_EN
                bus_error  = berr_q;
`endif
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; covers the timeout path when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic [3:0]  req_byte_enable;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
`ifdef LSU_TIMEOUT_EN
    logic        bus_error;
`endif
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    load_store_unit #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_f3          (req_f3),
        .req_byte_enable (req_byte_enable),
        .req_wdata       (req_wdata),
        .stall           (stall),
        .done            (done),
        .load_data       (load_data),
        .misaligned      (misaligned),
`ifdef LSU_TIMEOUT_EN
        .bus_error       (bus_error),
`endif
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_wstrb       (mem_wstrb),
        .mem_wdata       (mem_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_ready  (mem_resp_ready),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [3:0] be, input logic [31:0] wd);
        req_valid       = 1'b1;
        req_write       = wr;
        req_addr        = addr;
        req_f3          = f3;
        req_byte_enable = be;
        req_wdata       = wd;
    endtask

    // Load with an always-ready memory: done must appear exactly at cycle 3
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [3:0] be, input logic [31:0] rdata,
                            input logic [31:0] exp);
        drive_req(1'b0, addr, f3, be, 32'h0);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        #1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c0_mreq"}, 32'(mem_req_valid), 32'd0);
        cyc();
        chk({tag, "_c1_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c1_mreq"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_c1_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_c1_wstrb"}, 32'(mem_wstrb), 32'd0);
        cyc();
        chk({tag, "_c2_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c2_rrdy"}, 32'(mem_resp_ready), 32'd1);
        chk({tag, "_c2_done"}, 32'(done), 32'd0);
        cyc();
        chk({tag, "_c3_done"}, 32'(done), 32'd1);
        chk({tag, "_c3_stall"}, 32'(stall), 32'd0);
        chk({tag, "_c3_data"}, load_data, exp);
        chk({tag, "_c3_mis"}, 32'(misaligned), 32'd0);
        req_valid      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        cyc();
        chk({tag, "_c4_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_addr        = '0;
        req_f3          = '0;
        req_byte_enable = '0;
        req_wdata       = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_rdata       = '0;
        cyc();
        cyc();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mreq", 32'(mem_req_valid), 32'd0);
        chk("rst_rrdy", 32'(mem_resp_ready), 32'd0);
        chk("rst_data", load_data, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        cyc();

        // LB at 0x103: top byte 0x80 sign-extended
        run_load("lb", 32'h0000_0103, 3'b000, 4'b1000, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("lbu", 32'h0000_0101, 3'b100, 4'b0010, 32'h0000_F500, 32'h0000_00F5);
        run_load("lh", 32'h0000_0000, 3'b001, 4'b0011, 32'h0000_8001, 32'hFFFF_8001);
        run_load("bad_f3", 32'h0000_0000, 3'b011, 4'b1111, 32'h1234_5678, 32'h0);

        // SH at 0x202 with ready held off for 4 cycles; inputs change after accept
        drive_req(1'b1, 32'h0000_0202, 3'b001, 4'b1100, 32'hBEEF_0000);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("sh_c0_stall", 32'(stall), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            req_addr  = 32'h0000_0FFF;
            req_wdata = 32'h0;
            #1;
            chk("sh_req_valid", 32'(mem_req_valid), 32'd1);
            chk("sh_addr", mem_addr, 32'h0000_0200);
            chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
            chk("sh_wdata", mem_wdata, 32'hBEEF_0000);
            chk("sh_done_wait", 32'(done), 32'd0);
        end
        cyc();
        mem_req_ready = 1'b1;
        #1;
        chk("sh_c5_mreq", 32'(mem_req_valid), 32'd1);
        chk("sh_c5_wstrb", 32'(mem_wstrb), 32'hC);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        chk("sh_c6_rrdy", 32'(mem_resp_ready), 32'd1);
        chk("sh_c6_mreq", 32'(mem_req_valid), 32'd0);
        cyc();
        chk("sh_c7_done", 32'(done), 32'd1);
        chk("sh_c7_data", load_data, 32'h0);
        req_valid      = 1'b0;
        mem_resp_valid = 1'b0;
        cyc();
        chk("sh_c8_done", 32'(done), 32'd0);

        // Mask 0 (halfword at offset 3): no memory traffic
        drive_req(1'b0, 32'h0000_0003, 3'b001, 4'b0000, 32'h0);
        #1;
        chk("mis_c0_mreq", 32'(mem_req_valid), 32'd0);
        chk("mis_c0_stall", 32'(stall), 32'd1);
        cyc();
        chk("mis_c1_done", 32'(done), 32'd1);
        chk("mis_c1_mis", 32'(misaligned), 32'd1);
        chk("mis_c1_mreq", 32'(mem_req_valid), 32'd0);
        chk("mis_c1_data", load_data, 32'h0);
        chk("mis_c1_stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        cyc();
        chk("mis_c2_done", 32'(done), 32'd0);
        chk("mis_c2_mis", 32'(misaligned), 32'd0);

        // LHU at 0x2 with a stray response during REQ and a late real one
        drive_req(1'b0, 32'h0000_0002, 3'b101, 4'b1100, 32'h0);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1111_2222;
        #1;
        cyc();
        chk("lhu_c1_rrdy", 32'(mem_resp_ready), 32'd0);
        cyc();
        chk("lhu_c2_mreq", 32'(mem_req_valid), 32'd1);
        chk("lhu_c2_done", 32'(done), 32'd0);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        cyc();
        mem_req_ready = 1'b0;
        #1;
        chk("lhu_c3_rrdy", 32'(mem_resp_ready), 32'd1);
        cyc();
        chk("lhu_c4_done", 32'(done), 32'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hABCD_0000;
        cyc();
        chk("lhu_c5_done", 32'(done), 32'd1);
        chk("lhu_c5_data", load_data, 32'h0000_ABCD);
        req_valid      = 1'b0;
        mem_resp_valid = 1'b0;
        cyc();

        // Reset while waiting in RESP
        drive_req(1'b1, 32'h0000_0014, 3'b010, 4'b1111, 32'h5555_AAAA);
        mem_req_ready = 1'b1;
        #1;
        cyc();
        cyc();
        req_valid     = 1'b0;
        mem_req_ready = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rr_resp_rrdy", 32'(mem_resp_ready), 32'd1);
        cyc();
        chk("rr_stall", 32'(stall), 32'd0);
        chk("rr_rrdy", 32'(mem_resp_ready), 32'd0);
        chk("rr_mreq", 32'(mem_req_valid), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_addr", mem_addr, 32'h0);
        chk("rr_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rr_wdata", mem_wdata, 32'h0);
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        cyc();
        chk("rr_no_done", 32'(done), 32'd0);
        mem_resp_valid = 1'b0;
        run_load("lw", 32'h0000_0020, 3'b010, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

`ifdef LSU_TIMEOUT_EN
        // Memory never ready: error exactly 10 cycles after entering REQ
        drive_req(1'b0, 32'h0000_0040, 3'b010, 4'b1111, 32'h0);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("to_wait_done", 32'(done), 32'd0);
            chk("to_wait_berr", 32'(bus_error), 32'd0);
        end
        cyc();
        chk("to_done", 32'(done), 32'd1);
        chk("to_berr", 32'(bus_error), 32'd1);
        chk("to_data", load_data, 32'h0);
        chk("to_mreq", 32'(mem_req_valid), 32'd0);
        req_valid = 1'b0;
        cyc();
        chk("to_berr_clr", 32'(bus_error), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
